// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRERST = 2'd1,
    RUN    = 2'd2,
    FIN    = 2'd3
  } run_state_e;

  localparam int unsigned RST_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF    = 32'h0000_FFF0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Core run sequencer: hold core in reset, run it until halt, then present results.
// Optional run watchdog compiled in with RUN_SEQUENCER_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | core held in reset, waiting for req
// PRERST | core reset held for RST_CYCLES cycles
// RUN    | core enabled, counting run cycles
// FIN    | run ended, core state held, done until req drops
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int          CNT_W      = 16,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt_i,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int PRE_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RST_CYCLES - 1);

  run_state_e       state;
  run_state_e       next_state;
  logic [PRE_W-1:0] pre_cnt;
  logic             start;
  logic             pre_done;
  logic             wd_hit;
  logic             core_rst_d;
  logic             core_en_d;
  logic             busy_d;
  logic             done_d;

  assign start    = (state == IDLE) && req;
  assign pre_done = (pre_cnt == PRE_LAST);

  sat_counter #(.W(PRE_W)) u_pre_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (start),
    .en    (state == PRERST),
    .count (pre_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (start),
    .en    (state == RUN),
    .count (cycle_cnt)
  );

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  // Zero-extended compare so a narrow counter can never alias the limit.
  assign wd_hit = ((32'(cycle_cnt) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else if (start) begin
      timeout <= 1'b0;
    end else if ((state == RUN) && req && !halt_i && wd_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_hit         = 1'b0;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_rst_o <= 1'b1;
      core_en_o  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      core_rst_o <= core_rst_d;
      core_en_o  <= core_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Abort on req drop takes priority over halt/watchdog in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = PRERST;
      PRERST:  if (!req) next_state = IDLE;
               else if (pre_done) next_state = RUN;
      RUN:     if (!req) next_state = IDLE;
               else if (halt_i || wd_hit) next_state = FIN;
      FIN:     if (!req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from next_state so they register alongside the state.
  always_comb begin
    core_rst_d = 1'b1;
    core_en_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (next_state)
      IDLE:    core_rst_d = 1'b1;
      PRERST:  busy_d     = 1'b1;
      RUN: begin
        core_rst_d = 1'b0;
        core_en_d  = 1'b1;
        busy_d     = 1'b1;
      end
      FIN: begin
        core_rst_d = 1'b0;
        done_d     = 1'b1;
      end
      default: core_rst_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: main instance plus a 4-bit counter instance.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, halt_i, req4, halt4;
  logic        core_rst_o, core_en_o, busy, done, timeout;
  logic [15:0] cycle_cnt;
  logic        core_rst4, core_en4, busy4, done4, timeout4;
  logic [3:0]  cycle_cnt4;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  run_sequencer #(.RST_CYCLES(2), .CNT_W(16), .TIMEOUT(20)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req),
    .halt_i     (halt_i),
    .core_rst_o (core_rst_o),
    .core_en_o  (core_en_o),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt)
  );

  run_sequencer #(.RST_CYCLES(2), .CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req4),
    .halt_i     (halt4),
    .core_rst_o (core_rst4),
    .core_en_o  (core_en4),
    .busy       (busy4),
    .done       (done4),
    .timeout    (timeout4),
    .cycle_cnt  (cycle_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_io(input string tag, input logic r, input logic e, input logic b,
                           input logic d, input logic t, input logic [15:0] c);
    chk({tag, ".core_rst"}, 32'(core_rst_o), 32'(r));
    chk({tag, ".core_en"},  32'(core_en_o),  32'(e));
    chk({tag, ".busy"},     32'(busy),       32'(b));
    chk({tag, ".done"},     32'(done),       32'(d));
    chk({tag, ".timeout"},  32'(timeout),    32'(t));
    chk({tag, ".cnt"},      32'(cycle_cnt),  32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; req = 1'b0; halt_i = 1'b0; req4 = 1'b0; halt4 = 1'b0;
    #2 rst_n = 1'b0;
    #4 expect_io("reset", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_io("idle_noreq", 1, 0, 0, 0, 0, 0);

    // basic run, halt in 10th RUN cycle
    req = 1'b1;
    tick(); expect_io("pre1", 1, 0, 1, 0, 0, 0);
    tick(); expect_io("pre2", 1, 0, 1, 0, 0, 0);
    tick(); expect_io("run1", 0, 1, 1, 0, 0, 0);
    tick(9); chk("run10.cnt", 32'(cycle_cnt), 32'd9);
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    expect_io("fin", 0, 0, 0, 1, 0, 10);
    tick(); expect_io("fin_hold", 0, 0, 0, 1, 0, 10);
    req = 1'b0;
    tick(); expect_io("fin_exit", 1, 0, 0, 0, 0, 10);

    // abort in 3rd RUN cycle
    req = 1'b1;
    tick(); expect_io("ab_pre", 1, 0, 1, 0, 0, 0);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      tick(); chk("ab_run.done", 32'(done), 32'd0);
    end
    chk("ab_run3.cnt", 32'(cycle_cnt), 32'd2);
    req = 1'b0;
    tick(); expect_io("abort", 1, 0, 0, 0, 0, 3);

    // async reset mid-run at cycle_cnt=5
    req = 1'b1;
    tick(3); tick(5);
    expect_io("ar_run", 0, 1, 1, 0, 0, 5);
    #3 rst_n = 1'b0;
    #1 expect_io("ar_async", 1, 0, 0, 0, 0, 0);
    req = 1'b0;
    #1 rst_n = 1'b1;
    req = 1'b1;
    #1 chk("ar_noedge.busy", 32'(busy), 32'd0);
    tick(); chk("ar_first.busy", 32'(busy), 32'd1);
    req = 1'b0;
    tick(); expect_io("ar_idle", 1, 0, 0, 0, 0, 0);

    // halt held through IDLE and PRERST
    halt_i = 1'b1;
    tick(); expect_io("hh_idle", 1, 0, 0, 0, 0, 0);
    req = 1'b1;
    tick(); expect_io("hh_pre1", 1, 0, 1, 0, 0, 0);
    tick(); expect_io("hh_pre2", 1, 0, 1, 0, 0, 0);
    tick(); expect_io("hh_run1", 0, 1, 1, 0, 0, 0);
    tick(); expect_io("hh_fin", 0, 0, 0, 1, 0, 1);
    halt_i = 1'b0; req = 1'b0;
    tick();

`ifdef RUN_SEQUENCER_WATCHDOG_EN
    req = 1'b1;
    tick(3); tick(19);
    expect_io("wd_run19", 0, 1, 1, 0, 0, 19);
    tick(); expect_io("wd_fire", 0, 0, 0, 1, 1, 20);
    req = 1'b0;
    tick(); expect_io("wd_idle", 1, 0, 0, 0, 1, 20);
    req = 1'b1;
    tick(); expect_io("wd_clr", 1, 0, 1, 0, 0, 0);
    tick(2); tick(19);
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    expect_io("wd_tie", 0, 0, 0, 1, 0, 20);
    req = 1'b0;
    tick();
`else
    req = 1'b1;
    tick(3); tick(30);
    expect_io("nowd_run", 0, 1, 1, 0, 0, 30);
    halt_i = 1'b1; tick(); halt_i = 1'b0;
    expect_io("nowd_fin", 0, 0, 0, 1, 0, 31);
    req = 1'b0;
    tick();
`endif

    // saturation on the 4-bit instance
    req4 = 1'b1;
    tick(3); tick(15);
    chk("sat15.cnt", 32'(cycle_cnt4), 32'd15);
    tick(4);
    chk("sat19.cnt", 32'(cycle_cnt4), 32'd15);
    halt4 = 1'b1; tick(); halt4 = 1'b0;
    chk("sat_fin.done", 32'(done4), 32'd1);
    chk("sat_fin.cnt", 32'(cycle_cnt4), 32'd15);
    chk("sat_fin.timeout", 32'(timeout4), 32'd0);
    req4 = 1'b0;
    tick(); chk("sat_exit.done", 32'(done4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port clk clocks all state; port reset is asynchronous, active-low.
REQ-002 The block SHALL expose parameters (name, default, meaning):
- RST_CYCLES, 2, number of cycles the core is held in reset before a run.
- CNT_W, 16, width of the cycle counter.
- TIMEOUT, 16'hFFF0, watchdog limit in run cycles (used only with the watchdog compiled in).
REQ-003 The block SHALL expose ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, async active-low reset.
- req, in, 1, host run request, level.
- halt_i, in, 1, core halt indication (program end).
- core_rst_o, out, 1, synchronous reset to the core.
- core_en_o, out, 1, core advance enable.
- busy, out, 1, run in progress.
- done, out, 1, run finished.
- timeout, out, 1, run ended by watchdog.
- cycle_cnt, out, CNT_W, run cycles of the last or current run.

Function
REQ-004 The block SHALL implement a FSM with states IDLE, PRERST, RUN and FIN, all outputs registered.
REQ-005 IDLE: core_rst_o=1, core_en_o=0, busy=0, done=0; req=1 SHALL move to PRERST next edge, clearing cycle_cnt and timeout.
REQ-006 PRERST: core_rst_o=1, busy=1; it SHALL last exactly RST_CYCLES cycles, then move to RUN.
REQ-007 RUN: core_rst_o=0, core_en_o=1, busy=1; cycle_cnt SHALL increment by 1 each RUN cycle, including the cycle halt_i is sampled high.
REQ-008 In RUN, halt_i=1 SHALL move to FIN next edge; core_en_o SHALL be 0 from that edge.
REQ-009 FIN: done=1, busy=0, core_en_o=0, core_rst_o=0 (core state held for inspection); cycle_cnt and timeout SHALL be frozen.
REQ-010 FIN SHALL be left only when req=0, moving to IDLE; done SHALL fall on that edge (four-phase handshake).
REQ-011 req=0 in PRERST or RUN SHALL abort to IDLE next edge, with done=0 and cycle_cnt retaining its last value.
REQ-012 cycle_cnt SHALL saturate at all-ones and never wrap.
REQ-013 halt_i SHALL be ignored outside RUN.
REQ-014 req held high in IDLE after a run SHALL NOT be possible: FIN exits only on req=0, so each run needs a fresh req rise.

Reset
REQ-015 Asserting reset SHALL asynchronously force IDLE, core_rst_o=1, core_en_o=0, busy=0, done=0, timeout=0 and cycle_cnt=0, including mid-run.
REQ-016 After reset deasserts, the first transition SHALL require a clk edge with req=1.

Configuration
REQ-017 With macro RUN_SEQUENCER_WATCHDOG_EN defined, RUN SHALL move to FIN with timeout=1 on the edge where cycle_cnt would reach TIMEOUT without halt_i.
REQ-018 If halt_i and the watchdog limit coincide, halt SHALL win and timeout SHALL be 0.
REQ-019 With RUN_SEQUENCER_WATCHDOG_EN undefined, timeout SHALL be tied 0, TIMEOUT SHALL be unused, and RUN SHALL wait indefinitely for halt_i.

Structure
REQ-020 The shared package run_seq_pkg SHALL hold the FSM state enum (IDLE, PRERST, RUN, FIN) and default constants for RST_CYCLES and TIMEOUT.
REQ-021 The saturating counter SHALL be one sub-module, sat_counter (clear, enable, saturate-at-max, count output), used for both the PRERST counter and cycle_cnt.
REQ-022 All other logic SHALL be in run_sequencer; the block SHALL target 120-400 RTL lines.

Verification
REQ-023 Basic run: req=1, halt_i at the 10th RUN cycle -> core_rst_o=1 for 2 cycles, done=1, cycle_cnt=10, timeout=0; req=0 -> done=0 next edge.
REQ-024 Abort: req=1, then req=0 at the 3rd RUN cycle -> IDLE next edge, core_rst_o=1, done never asserted, cycle_cnt=3.
REQ-025 Async reset mid-RUN at cycle_cnt=5 -> all outputs at reset values immediately, with no clk edge needed.
REQ-026 Watchdog (macro defined, TIMEOUT=20), halt_i never high -> FIN with cycle_cnt=20 and timeout=1; with halt_i at cycle 20 -> timeout=0.
REQ-027 Saturation (macro undefined, CNT_W=4), halt_i at the 20th RUN cycle -> cycle_cnt=15.
REQ-028 halt_i=1 held during IDLE and PRERST -> no early FIN; FIN occurs after the first RUN cycle with cycle_cnt=1.
